la_capture_ctrl: RTL
====================

# la_capture_ctrl

Parametrised multi-channel capture controller for the logic analyser. It is the successor to the fixed 8-bit sample controller. It samples `CH_W` input channels on the sample strobe from the frequency divider and writes them into a circular sample RAM of `2**ADDR_W` entries. It supports a per-channel trigger mask, pattern and edge trigger modes, a programmable pre-trigger depth, and reports the window start address for the wave display.

## Interface
- `CH_W`, default 8: number of sampled channels and the RAM data width.
- `ADDR_W`, default 10: RAM address width. Depth `DEPTH = 2**ADDR_W`.
- `iSysClk`, input, 1: system clock. This is the only clock.
- `iRst`, input, 1: reset, synchronous and active-high.
- `clk_en`, input, 1: sample strobe, one `iSysClk` cycle wide.
- `arm`, input, 1: start-capture pulse. It latches all configuration inputs.
- `data_in`, input, `CH_W`: channel inputs.
- `trig_mask`, input, `CH_W`: channels that take part in the trigger condition.
- `trig_pattern`, input, `CH_W`: pattern value used by mode 5.
- `trig_mode`, input, 3: trigger mode. Decoding is given under Operation.
- `pre_num`, input, `ADDR_W`: number of samples stored before the trigger sample.
- `wr_addr`, output, `ADDR_W`: RAM write address.
- `wr_data`, output, `CH_W`: RAM write data.
- `wr_en`, output, 1: RAM write strobe.
- `start_addr`, output, `ADDR_W`: address of the oldest sample in the captured window.
- `trig_addr`, output, `ADDR_W`: address of the trigger sample.
- `busy`, output, 1: high while a capture is in progress.
- `finished`, output, 1: high while a completed capture is held.

## Operation
- Config latch: `arm` copies `trig_mask`, `trig_pattern`, `trig_mode` and `pre_num` into internal registers. The controller then ignores these inputs until the next `arm`.
- Pre-trigger clamp: `pre_eff = min(pre_num, DEPTH-1)`. Post-trigger count `post = DEPTH-1-pre_eff`.
- States:
  - IDLE: entered after reset. `arm` moves to PRE.
  - PRE: writes samples until `pre_eff` samples are stored, then moves to WAIT. When `pre_eff = 0`, PRE moves to WAIT on the cycle after `arm`.
  - WAIT: writes continuously into the circular buffer and evaluates the trigger on every sample. When the trigger hits, it moves to POST. When `post = 0`, it moves directly to DONE.
  - POST: writes `post` further samples, then moves to DONE.
  - DONE: `finished = 1` and no writes occur. `arm` moves to PRE.
- Sampling: every `clk_en` cycle in PRE, WAIT or POST stores one sample. `wr_data <= data_in`, `wr_en` pulses, and `wr_addr` increments modulo `DEPTH` after each write. The first write after `arm` goes to address 0.
- Trigger inputs: `cur` is the sample being written and `prv` is the previous sample. Edge terms are computed per masked channel only.
- Trigger modes:
  - 0: any masked channel rises (`~prv & cur`).
  - 1: any masked channel falls.
  - 2: any masked channel changes.
  - 3: all masked channels are high.
  - 4: all masked channels are low.
  - 5: `(cur ^ trig_pattern) & trig_mask == 0`.
  - 6: immediate; the first WAIT sample triggers.
  - 7: reserved. Behaves as mode 6.
- A zero mask never triggers in modes 0-2. It always triggers in modes 3-5.
- Edge suppression: the first sample after `arm` has no `prv`, so edge modes cannot trigger on it.
- On the trigger sample:
  - `trig_addr <=` the address of that sample.
  - `start_addr <= (trig_addr - pre_eff) mod DEPTH`, computed at `ADDR_W` width with natural wrap.
- Buffer content after DONE: `DEPTH` consecutive samples starting at `start_addr`. These are `pre_eff` pre-trigger samples, the trigger sample, and `post` post-trigger samples.
- Re-arm: `arm` in any state, including mid-capture, aborts the current capture and restarts PRE.
  - `wr_addr` returns to 0.
  - `finished` clears.
  - `start_addr` and `trig_addr` keep their old values until a new trigger.
- `busy` is 1 in PRE, WAIT and POST.

## Timing
- All outputs are registered.
- Reset values: `wr_addr = 0`, `wr_data = 0`, `wr_en = 0`, `start_addr = 0`, `trig_addr = 0`, `busy = 0`, `finished = 0`. State is IDLE.
- `arm` at cycle n gives `busy = 1` at n+1. A `clk_en` at cycle n itself is not sampled.
- `clk_en` at cycle n gives `wr_en`, `wr_data` and `wr_addr` valid at n+1 (latency 1). `wr_addr` advances at n+2.
- Trigger sample at cycle n: `trig_addr` and `start_addr` are valid at n+1.
- Last POST sample at cycle n: `finished = 1` and `busy = 0` at n+1.
- `iRst` has priority over `arm`.
- `clk_en` held high samples every cycle, with no gaps.

## Test plan
- **Immediate trigger.** `ADDR_W=4`, mode 6, `pre_num=3`, `data_in` counts 0,1,2… with `clk_en` every cycle.
  - Required: exactly 16 writes, to addresses 0..15.
  - `trig_addr=3`, `start_addr=0`, `finished` one cycle after the 16th write.
- **Rising edge with wrap.** `ADDR_W=4`, mode 0, mask `8'h01`, `pre_num=5`. Channel 0 rises on the 20th sample after `arm`.
  - Required: `trig_addr=(19 mod 16)=3`, `start_addr=14`.
  - Exactly 10 post writes follow the trigger.
- **Pattern and first-sample rules.** Mode 5, pattern `8'hA5`, mask `8'hF0`. `data_in=8'hA0` is present from the first sample.
  - Required: trigger on the first WAIT sample.
  - Separately, mode 0 with channel 0 already high at `arm`: no trigger on the first sample.
- **Clamp.** `pre_num = 10'h3FF`, `ADDR_W=10`.
  - Required: trigger enters DONE on the next cycle with 0 post writes.
  - `start_addr = trig_addr + 1 (mod 1024)`.
- **Abort.** Re-`arm` during POST.
  - Required: `wr_addr` restarts at 0 and `finished` stays 0.
  - `start_addr` and `trig_addr` hold their old values until the new trigger.
  - `iRst` mid-WAIT returns all outputs to 0.
- **Sparse strobe.** `clk_en` every 8 cycles.
  - Required: `wr_en` only one cycle after each strobe.
  - No writes in IDLE or DONE.

Source files
------------

// File: rtl/la_capture_ctrl_if.sv
// RAM write port of the logic-analyser capture controller: address, data and write strobe.
interface la_capture_ctrl_if #(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] wr_addr;
  logic [CH_W-1:0]   wr_data;
  logic              wr_en;

  modport master (output wr_addr, output wr_data, output wr_en);
  modport slave  (input  wr_addr, input  wr_data, input  wr_en);
endinterface

// File: rtl/la_capture_ctrl.sv
// Multi-channel capture controller: fills a circular sample RAM around a masked
// pattern/edge trigger with a programmable pre-trigger depth.
module la_capture_ctrl #(
  parameter int CH_W   = 8,
  parameter int ADDR_W = 10
) (
  input  logic              iSysClk,
  input  logic              iRst,
  input  logic              clk_en,
  input  logic              arm,
  input  logic [CH_W-1:0]   data_in,
  input  logic [CH_W-1:0]   trig_mask,
  input  logic [CH_W-1:0]   trig_pattern,
  input  logic [2:0]        trig_mode,
  input  logic [ADDR_W-1:0] pre_num,
  la_capture_ctrl_if.master wr_bus,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              finished
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]   CH_ZERO   = {CH_W{1'b0}};

  function automatic logic trig_hit(
    input logic [2:0]      mode,
    input logic [CH_W-1:0] mask,
    input logic [CH_W-1:0] pattern,
    input logic [CH_W-1:0] cur,
    input logic [CH_W-1:0] prv,
    input logic            first
  );
    logic [CH_W-1:0] rise;
    logic [CH_W-1:0] fall;
    logic [CH_W-1:0] chg;
    logic            hit;
    rise = ~prv & cur & mask;
    fall = prv & ~cur & mask;
    chg  = (prv ^ cur) & mask;
    // Edge modes have no previous sample to compare against right after arm.
    case (mode)
      3'd0:    hit = ~first & (|rise);
      3'd1:    hit = ~first & (|fall);
      3'd2:    hit = ~first & (|chg);
      3'd3:    hit = ((cur & mask) == mask);
      3'd4:    hit = ((cur & mask) == CH_ZERO);
      3'd5:    hit = (((cur ^ pattern) & mask) == CH_ZERO);
      default: hit = 1'b1;
    endcase
    return hit;
  endfunction

  state_e            state_q, state_d;
  logic [CH_W-1:0]   mask_q, mask_d;
  logic [CH_W-1:0]   pattern_q, pattern_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] pre_eff_q, pre_eff_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]   prv_q, prv_d;
  logic              first_q, first_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CH_W-1:0]   wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic              busy_q, busy_d;
  logic              finished_q, finished_d;

  logic [ADDR_W-1:0] post_s;
  logic [ADDR_W-1:0] cnt_inc_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic              take_s;
  logic              hit_s;

  // DEPTH-1-pre_eff is the bitwise complement at ADDR_W width.
  assign post_s     = ~pre_eff_q;
  assign cnt_inc_s  = cnt_q + ADDR_ONE;
  // wr_addr still points at the last write until its deferred increment lands.
  assign cur_addr_s = wr_en_q ? (wr_addr_q + ADDR_ONE) : wr_addr_q;
  assign hit_s      = trig_hit(mode_q, mask_q, pattern_q, data_in, prv_q, first_q);

  // Sample acceptance: strobe in a capture state, never on an arm cycle.
  always_comb begin
    take_s = 1'b0;
    if (arm) begin
      take_s = 1'b0;
    end else begin
      case (state_q)
        S_PRE:   take_s = clk_en & (pre_eff_q != ADDR_ZERO);
        S_WAIT:  take_s = clk_en;
        S_POST:  take_s = clk_en;
        default: take_s = 1'b0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge iSysClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arm restarts the capture from any state.
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = S_PRE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_PRE: begin
          if (pre_eff_q == ADDR_ZERO) begin
            state_d = S_WAIT;
          end else if (take_s && (cnt_inc_s == pre_eff_q)) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_PRE;
          end
        end
        S_WAIT: begin
          if (take_s && hit_s) begin
            state_d = (post_s == ADDR_ZERO) ? S_DONE : S_POST;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_POST: begin
          if (take_s && (cnt_inc_s == post_s)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_POST;
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values.
  always_comb begin
    mask_d       = mask_q;
    pattern_d    = pattern_q;
    mode_d       = mode_q;
    pre_eff_d    = pre_eff_q;
    cnt_d        = cnt_q;
    prv_d        = prv_q;
    first_d      = first_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_en_d      = 1'b0;
    start_addr_d = start_addr_q;
    trig_addr_d  = trig_addr_q;
    if (arm) begin
      mask_d    = trig_mask;
      pattern_d = trig_pattern;
      mode_d    = trig_mode;
      // pre_num is ADDR_W wide, so it can never exceed DEPTH-1.
      pre_eff_d = pre_num;
      cnt_d     = ADDR_ZERO;
      first_d   = 1'b1;
      wr_addr_d = ADDR_ZERO;
    end else begin
      if (wr_en_q) begin
        wr_addr_d = wr_addr_q + ADDR_ONE;
      end else begin
        wr_addr_d = wr_addr_q;
      end
      if (take_s) begin
        wr_en_d   = 1'b1;
        wr_data_d = data_in;
        prv_d     = data_in;
        first_d   = 1'b0;
        if (state_q == S_WAIT) begin
          cnt_d = ADDR_ZERO;
          if (hit_s) begin
            trig_addr_d  = cur_addr_s;
            start_addr_d = cur_addr_s - pre_eff_q;
          end else begin
            trig_addr_d  = trig_addr_q;
            start_addr_d = start_addr_q;
          end
        end else begin
          cnt_d = cnt_inc_s;
        end
      end else begin
        wr_en_d = 1'b0;
      end
    end
    busy_d     = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    finished_d = (state_d == S_DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge iSysClk) begin
    if (iRst) begin
      mask_q       <= CH_ZERO;
      pattern_q    <= CH_ZERO;
      mode_q       <= 3'd0;
      pre_eff_q    <= ADDR_ZERO;
      cnt_q        <= ADDR_ZERO;
      prv_q        <= CH_ZERO;
      first_q      <= 1'b0;
      wr_addr_q    <= ADDR_ZERO;
      wr_data_q    <= CH_ZERO;
      wr_en_q      <= 1'b0;
      start_addr_q <= ADDR_ZERO;
      trig_addr_q  <= ADDR_ZERO;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      pattern_q    <= pattern_d;
      mode_q       <= mode_d;
      pre_eff_q    <= pre_eff_d;
      cnt_q        <= cnt_d;
      prv_q        <= prv_d;
      first_q      <= first_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_en_q      <= wr_en_d;
      start_addr_q <= start_addr_d;
      trig_addr_q  <= trig_addr_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
    end
  end

  assign wr_bus.wr_addr = wr_addr_q;
  assign wr_bus.wr_data = wr_data_q;
  assign wr_bus.wr_en   = wr_en_q;
  assign start_addr     = start_addr_q;
  assign trig_addr      = trig_addr_q;
  assign busy           = busy_q;
  assign finished       = finished_q;

endmodule
